mult16_seq_ctrl: RTL and testbench

//  Sequential 16x16 signed multiplier built around ONE shared 8-bit signed multiplier (hlr_bm1_mod).

---
 rtl/mult16_seq_pkg.sv | 33 +++
 rtl/hlr_bm1_mod.sv | 11 +
 rtl/mult16_seq_ctrl.sv | 130 +++++++++++++
 tb/tb_mult16_seq_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult16_seq_pkg.sv
// Shared types and constants for the sequential 16x16 signed multiplier.
package mult16_seq_pkg;

  localparam int unsigned OP_W       = 16;
  localparam int unsigned DIGIT_W    = 7;
  localparam int unsigned MULT_W     = DIGIT_W + 1;
  localparam int unsigned PROD_W     = 2 * MULT_W;
  localparam int unsigned NUM_DIGITS = (OP_W + DIGIT_W - 1) / DIGIT_W;
  localparam int unsigned NUM_PRODS  = NUM_DIGITS * NUM_DIGITS;
  localparam int unsigned ACC_W      = 32;
  localparam int unsigned K_W        = 4;
  localparam int unsigned SH_W       = 5;
  localparam int unsigned TOP_W      = OP_W - 2 * DIGIT_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Signed 8-bit radix-2^7 digit: low digits zero-extended, top digit sign-extended.
  function automatic logic signed [MULT_W-1:0] digit_sel(input logic [OP_W-1:0] x,
                                                         input logic [1:0]      idx);
    logic signed [MULT_W-1:0] d;
    case (idx)
      2'd0:    d = {1'b0, x[DIGIT_W-1:0]};
      2'd1:    d = {1'b0, x[2*DIGIT_W-1:DIGIT_W]};
      default: d = {{(MULT_W-TOP_W){x[OP_W-1]}}, x[OP_W-1:2*DIGIT_W]};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/hlr_bm1_mod.sv
// Shared 8x8 signed multiplier primitive (combinational).
module hlr_bm1_mod (
  input  logic signed [7:0]  x,
  input  logic signed [7:0]  y,
  output logic signed [15:0] prod
);

  // Full-precision signed product.
  assign prod = x * y;

endmodule

// File: rtl/mult16_seq_ctrl.sv
// Sequential 16x16 signed multiplier: nine digit products through one 8x8 multiplier.
// Optional build macro MULT16_SEQ_ZSKIP_EN: zero operand skips straight to DONE.
module mult16_seq_ctrl
  import mult16_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [ACC_W-1:0]  o_z
);

  if (DATA_W != OP_W) begin : g_bad_width
    $error("mult16_seq_ctrl: only DATA_W=16 is supported");
  end

  state_t                    state_q, state_d;
  logic [K_W-1:0]            k_q, k_d;
  logic [ACC_W-1:0]          acc_q, acc_d;
  logic [OP_W-1:0]           a_q, a_d, b_q, b_d;
  logic [ACC_W-1:0]          z_q, z_d;
  logic                      ready_q, ready_d;
  logic                      valid_q, valid_d;
  logic [1:0]                di, dj;
  logic [SH_W-1:0]           sh;
  logic signed [MULT_W-1:0]  mx, my;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   pe;

  // Digit select and weight for the current product; multiplier idles at zero.
  always_comb begin
    di = 2'd0;
    dj = 2'd0;
    mx = '0;
    my = '0;
    sh = '0;
    if (state_q == RUN) begin
      di = 2'(k_q / K_W'(NUM_DIGITS));
      dj = 2'(k_q % K_W'(NUM_DIGITS));
      mx = digit_sel(a_q, di);
      my = digit_sel(b_q, dj);
      sh = SH_W'(DIGIT_W * (32'(di) + 32'(dj)));
    end
  end

  hlr_bm1_mod u_mult (
    .x    (mx),
    .y    (my),
    .prod (prod)
  );

  // Next-state, accumulator and output register inputs.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    z_d     = z_q;
    pe      = ACC_W'(prod) <<< sh;
    case (state_q)
      IDLE: begin
        if (i_valid && ready_q) begin
          a_d     = OP_W'(i_a);
          b_d     = OP_W'(i_b);
          acc_d   = '0;
          k_d     = '0;
          state_d = RUN;
`ifdef MULT16_SEQ_ZSKIP_EN
          if ((i_a == '0) || (i_b == '0)) begin
            z_d     = '0;
            state_d = DONE;
          end
`endif
        end
      end
      RUN: begin
        acc_d = acc_q + pe;
        if (k_q == K_W'(NUM_PRODS - 1)) begin
          z_d     = acc_d;
          state_d = DONE;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      DONE: begin
        if (i_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    valid_d = (state_d == DONE);
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      z_q     <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      z_q     <= z_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_z     = z_q;

endmodule

// File: tb/tb_mult16_seq_ctrl.sv
// Self-checking bench for mult16_seq_ctrl against a plain a*b reference.
module tb_mult16_seq_ctrl;

  logic        i_clk;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] i_a;
  logic [15:0] i_b;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_z;

  int checks;
  int errors;

  mult16_seq_ctrl dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_a     (i_a),
    .i_b     (i_b),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_z     (o_z)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference: exact signed product.
  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    int sa;
    int sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    return 32'(sa * sb);
  endfunction

  // Reference: accept-to-valid latency in cycles.
  function automatic int exp_lat(input logic [15:0] a, input logic [15:0] b);
    int l;
    l = 10;
`ifdef MULT16_SEQ_ZSKIP_EN
    if (a == 16'd0 || b == 16'd0) l = 1;
`endif
    return l;
  endfunction

  // Drive one request; returns at the negedge where o_valid is first seen (lat=-1 on timeout).
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        output logic [31:0] z, output int lat);
    int n;
    n = 0;
    while (!o_ready && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    i_valid = 1'b1;
    i_a     = a;
    i_b     = b;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    i_a     = 16'($urandom);
    i_b     = 16'($urandom);
    n = 1;
    while (!o_valid && n < 40) begin
      @(negedge i_clk);
      n++;
    end
    lat = o_valid ? n : -1;
    z   = o_z;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    checks++;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", o_valid); end
    checks++;
    if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", o_ready); end
    checks++;
    if (o_z !== 32'd0) begin errors++; $display("FAIL reset_z got %h exp 0", o_z); end
    i_rst = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_directed();
    logic [15:0] av[3];
    logic [15:0] bv[3];
    logic [31:0] z;
    int lat;
    av[0] = 16'd3;      bv[0] = 16'hFFFB;
    av[1] = 16'h8000;   bv[1] = 16'h8000;
    av[2] = 16'h7FFF;   bv[2] = 16'h8000;
    i_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      run_op(av[t], bv[t], z, lat);
      checks++;
      if (z !== ref_mul(av[t], bv[t])) begin
        errors++; $display("FAIL directed_z[%0d] got %h exp %h", t, z, ref_mul(av[t], bv[t]));
      end
      checks++;
      if (lat !== exp_lat(av[t], bv[t])) begin
        errors++; $display("FAIL directed_lat[%0d] got %0d exp %0d", t, lat, exp_lat(av[t], bv[t]));
      end
      @(negedge i_clk);
    end
    checks++;
    if (ref_mul(16'h8000, 16'h8000) !== 32'h4000_0000 || z !== 32'(-1073709056)) begin
      errors++; $display("FAIL directed_boundary got %h exp %h", z, 32'(-1073709056));
    end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    i_ready = 1'b1;
    while (!o_ready) @(negedge i_clk);
    i_valid = 1'b1;
    i_a     = 16'd1234;
    i_b     = 16'd567;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      errors++; $display("FAIL midrun_reset_flags got ready=%b valid=%b exp ready=1 valid=0", o_ready, o_valid);
    end
    checks++;
    if (o_z !== 32'd0) begin errors++; $display("FAIL midrun_reset_z got %h exp 0", o_z); end
    seen = 0;
    repeat (15) begin
      @(negedge i_clk);
      if (o_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL midrun_no_valid got %0d valid cycles exp 0", seen); end
  endtask

  task automatic test_backpressure();
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] z;
    int lat;
    int bad;
    a = 16'h9C3A;
    b = 16'h2B71;
    i_ready = 1'b0;
    run_op(a, b, z, lat);
    checks++;
    if (z !== ref_mul(a, b)) begin errors++; $display("FAIL bp_z got %h exp %h", z, ref_mul(a, b)); end
    bad = 0;
    repeat (5) begin
      @(negedge i_clk);
      if (o_valid !== 1'b1 || o_z !== ref_mul(a, b) || o_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL bp_hold got %0d unstable cycles exp 0", bad); end
    i_ready = 1'b1;
    @(negedge i_clk);
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release got ready=%b valid=%b exp ready=1 valid=0", o_ready, o_valid);
    end
  endtask

  task automatic test_ignore_valid();
    logic [15:0] a1, b1, a2, b2;
    int cyc, acc1, acc2, lat1;
    bit got1, seen2, got2;
    a1 = 16'hF00D; b1 = 16'h0ABC;
    a2 = 16'd0;    b2 = 16'd0;
    i_ready = 1'b1;
    while (!o_ready) @(negedge i_clk);
    i_valid = 1'b1;
    i_a = a1; i_b = b1;
    cyc = 0; acc1 = 0; acc2 = 0; lat1 = -1;
    got1 = 0; seen2 = 0; got2 = 0;
    while (!got2 && cyc < 60) begin
      @(negedge i_clk);
      cyc++;
      if (o_valid && !seen2 && !got1) begin
        got1 = 1; lat1 = cyc;
        checks++;
        if (o_z !== ref_mul(a1, b1)) begin errors++; $display("FAIL ign_z1 got %h exp %h", o_z, ref_mul(a1, b1)); end
      end else if (o_valid && seen2) begin
        got2 = 1;
        checks++;
        if (o_z !== ref_mul(a2, b2)) begin errors++; $display("FAIL ign_z2 got %h exp %h", o_z, ref_mul(a2, b2)); end
      end
      i_a = 16'($urandom) | 16'h0001;
      i_b = 16'($urandom) | 16'h0100;
      if (o_ready && !seen2) begin
        seen2 = 1; acc2 = cyc; a2 = i_a; b2 = i_b;
      end
    end
    i_valid = 1'b0;
    checks++;
    if (lat1 !== 10) begin errors++; $display("FAIL ign_lat1 got %0d exp 10", lat1); end
    checks++;
    if (acc2 - acc1 !== 11) begin errors++; $display("FAIL ign_interval got %0d exp 11", acc2 - acc1); end
    checks++;
    if (!got2) begin errors++; $display("FAIL ign_second_result got none exp one"); end
    @(negedge i_clk);
  endtask

  task automatic test_zero();
    logic [31:0] z;
    int lat;
    i_ready = 1'b1;
    run_op(16'd0, 16'd1234, z, lat);
    checks++;
    if (z !== 32'd0) begin errors++; $display("FAIL zero_z got %h exp 0", z); end
    checks++;
    if (lat !== exp_lat(16'd0, 16'd1234)) begin
      errors++; $display("FAIL zero_lat got %0d exp %0d", lat, exp_lat(16'd0, 16'd1234));
    end
    @(negedge i_clk);
    run_op(16'hFFFF, 16'd0, z, lat);
    checks++;
    if (z !== 32'd0 || lat !== exp_lat(16'hFFFF, 16'd0)) begin
      errors++; $display("FAIL zero_b got z=%h lat=%0d exp z=0 lat=%0d", z, lat, exp_lat(16'hFFFF, 16'd0));
    end
    @(negedge i_clk);
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] z;
    int lat;
    int stall;
    int bad;
    for (int t = 0; t < 2000; t++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      case ($urandom_range(0, 15))
        0: a = 16'd0;
        1: b = 16'd0;
        2: a = 16'h8000;
        3: b = 16'h7FFF;
        default: ;
      endcase
      stall = int'($urandom_range(0, 3));
      i_ready = (stall == 0);
      run_op(a, b, z, lat);
      checks++;
      if (z !== ref_mul(a, b) || lat !== exp_lat(a, b)) begin
        errors++;
        $display("FAIL rand[%0d] a=%h b=%h got z=%h lat=%0d exp z=%h lat=%0d",
                 t, a, b, z, lat, ref_mul(a, b), exp_lat(a, b));
      end
      bad = 0;
      for (int s = 0; s < stall; s++) begin
        @(negedge i_clk);
        if (o_valid !== 1'b1 || o_z !== ref_mul(a, b)) bad++;
      end
      if (stall != 0) begin
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL rand_stall[%0d] got %0d unstable exp 0", t, bad); end
      end
      i_ready = 1'b1;
      @(negedge i_clk);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_a     = 16'd0;
    i_b     = 16'd0;
    test_reset();
    test_directed();
    test_reset_mid_run();
    test_backpressure();
    test_ignore_valid();
    test_zero();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
